// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encodings and helpers, also used by the
// instruction register and the data-register decode.
package jtag_pkg;

    localparam int TAP_STATE_W = 4;

    typedef enum logic [TAP_STATE_W-1:0] {
        TAP_EX2DR   = 4'h0,
        TAP_EX1DR   = 4'h1,
        TAP_SHDR    = 4'h2,
        TAP_PAUSEDR = 4'h3,
        TAP_SELIR   = 4'h4,
        TAP_UPDDR   = 4'h5,
        TAP_CAPDR   = 4'h6,
        TAP_SELDR   = 4'h7,
        TAP_EX2IR   = 4'h8,
        TAP_EX1IR   = 4'h9,
        TAP_SHIR    = 4'hA,
        TAP_PAUSEIR = 4'hB,
        TAP_RTI     = 4'hC,
        TAP_UPDIR   = 4'hD,
        TAP_CAPIR   = 4'hE,
        TAP_TLR     = 4'hF
    } tap_state_t;

    function automatic logic is_ir_column(input tap_state_t s);
        logic r;
        case (s)
            TAP_SELIR, TAP_CAPIR, TAP_SHIR, TAP_EX1IR,
            TAP_PAUSEIR, TAP_EX2IR, TAP_UPDIR: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine with a registered Moore decode of the
// IR/DR strobes, the TDO mux select and the TDO driver enable.
module tap_controller
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       RESET,
    input  logic       TMS,
    output logic [3:0] STATE,
    output logic       SELECT,
    output logic       ENABLE,
    output logic       TLR,
    output logic       CAPTURE_DR,
    output logic       SHIFT_DR,
    output logic       UPDATE_DR,
    output logic       CAPTURE_IR,
    output logic       SHIFT_IR,
    output logic       UPDATE_IR
);

    tap_state_t state_q, state_d;
    logic select_q, enable_q, tlr_q;
    logic capdr_q, shdr_q, upddr_q, capir_q, shir_q, updir_q;

    // Next-state graph; all 16 codes are legal, default is a safe fallback
    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:     state_d = TMS ? TAP_TLR     : TAP_RTI;
            TAP_RTI:     state_d = TMS ? TAP_SELDR   : TAP_RTI;
            TAP_SELDR:   state_d = TMS ? TAP_SELIR   : TAP_CAPDR;
            TAP_CAPDR:   state_d = TMS ? TAP_EX1DR   : TAP_SHDR;
            TAP_SHDR:    state_d = TMS ? TAP_EX1DR   : TAP_SHDR;
            TAP_EX1DR:   state_d = TMS ? TAP_UPDDR   : TAP_PAUSEDR;
            TAP_PAUSEDR: state_d = TMS ? TAP_EX2DR   : TAP_PAUSEDR;
            TAP_EX2DR:   state_d = TMS ? TAP_UPDDR   : TAP_SHDR;
            TAP_UPDDR:   state_d = TMS ? TAP_SELDR   : TAP_RTI;
            TAP_SELIR:   state_d = TMS ? TAP_TLR     : TAP_CAPIR;
            TAP_CAPIR:   state_d = TMS ? TAP_EX1IR   : TAP_SHIR;
            TAP_SHIR:    state_d = TMS ? TAP_EX1IR   : TAP_SHIR;
            TAP_EX1IR:   state_d = TMS ? TAP_UPDIR   : TAP_PAUSEIR;
            TAP_PAUSEIR: state_d = TMS ? TAP_EX2IR   : TAP_PAUSEIR;
            TAP_EX2IR:   state_d = TMS ? TAP_UPDIR   : TAP_SHIR;
            TAP_UPDIR:   state_d = TMS ? TAP_SELDR   : TAP_RTI;
            default:     state_d = TAP_TLR;
        endcase
    end

    // State register; outputs are decoded from the incoming state so they
    // are registered yet stay aligned with STATE
    always_ff @(posedge TCK) begin
        if (RESET) begin
            state_q  <= TAP_TLR;
            select_q <= 1'b0;
            enable_q <= 1'b0;
            tlr_q    <= 1'b1;
            capdr_q  <= 1'b0;
            shdr_q   <= 1'b0;
            upddr_q  <= 1'b0;
            capir_q  <= 1'b0;
            shir_q   <= 1'b0;
            updir_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            select_q <= is_ir_column(state_d);
            enable_q <= (state_d == TAP_SHDR) || (state_d == TAP_SHIR);
            tlr_q    <= (state_d == TAP_TLR);
            capdr_q  <= (state_d == TAP_CAPDR);
            shdr_q   <= (state_d == TAP_SHDR);
            upddr_q  <= (state_d == TAP_UPDDR);
            capir_q  <= (state_d == TAP_CAPIR);
            shir_q   <= (state_d == TAP_SHIR);
            updir_q  <= (state_d == TAP_UPDIR);
        end
    end

    assign STATE      = state_q;
    assign SELECT     = select_q;
    assign ENABLE     = enable_q;
    assign TLR        = tlr_q;
    assign CAPTURE_DR = capdr_q;
    assign SHIFT_DR   = shdr_q;
    assign UPDATE_DR  = upddr_q;
    assign CAPTURE_IR = capir_q;
    assign SHIFT_IR   = shir_q;
    assign UPDATE_IR  = updir_q;

endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: stimulus pushes expected states,
// a monitor compares STATE and all decoded outputs every TCK.
module tb_tap_controller;

    logic       TCK = 1'b0;
    logic       RESET;
    logic       TMS;
    logic [3:0] STATE;
    logic       SELECT, ENABLE, TLR;
    logic       CAPTURE_DR, SHIFT_DR, UPDATE_DR;
    logic       CAPTURE_IR, SHIFT_IR, UPDATE_IR;

    tap_controller dut (
        .TCK(TCK), .RESET(RESET), .TMS(TMS), .STATE(STATE),
        .SELECT(SELECT), .ENABLE(ENABLE), .TLR(TLR),
        .CAPTURE_DR(CAPTURE_DR), .SHIFT_DR(SHIFT_DR), .UPDATE_DR(UPDATE_DR),
        .CAPTURE_IR(CAPTURE_IR), .SHIFT_IR(SHIFT_IR), .UPDATE_IR(UPDATE_IR)
    );

    always #5 TCK = ~TCK;

    localparam logic [15:0] IR_MASK = 16'h6F10;

    int         checks = 0;
    int         errors = 0;
    int         phase  = 0;
    logic [3:0] exp_q[$];
    int         ph_q[$];
    logic [3:0] m_state = 4'hF;
    logic [31:0] covered = 32'h0;
    bit         count_en = 1'b0;
    int         sel_cnt, en_cnt, updir_cnt, shdr_cnt;

    logic [3:0] tgt   [16];
    logic [7:0] pbits [16];
    int         plen  [16];

    function automatic logic [3:0] ref_next(input logic [3:0] s, input logic t);
        case (s)
            4'hF: return t ? 4'hF : 4'hC;
            4'hC: return t ? 4'h7 : 4'hC;
            4'h7: return t ? 4'h4 : 4'h6;
            4'h6: return t ? 4'h1 : 4'h2;
            4'h2: return t ? 4'h1 : 4'h2;
            4'h1: return t ? 4'h5 : 4'h3;
            4'h3: return t ? 4'h0 : 4'h3;
            4'h0: return t ? 4'h5 : 4'h2;
            4'h5: return t ? 4'h7 : 4'hC;
            4'h4: return t ? 4'hF : 4'hE;
            4'hE: return t ? 4'h9 : 4'hA;
            4'hA: return t ? 4'h9 : 4'hA;
            4'h9: return t ? 4'hD : 4'hB;
            4'hB: return t ? 4'h8 : 4'hB;
            4'h8: return t ? 4'hD : 4'hA;
            4'hD: return t ? 4'h7 : 4'hC;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [8:0] ref_outs(input logic [3:0] s);
        return {IR_MASK[s], (s == 4'h2) || (s == 4'hA), s == 4'hF,
                s == 4'h6, s == 4'h2, s == 4'h5,
                s == 4'hE, s == 4'hA, s == 4'hD};
    endfunction

    task automatic drive(input logic t, input logic r, input logic [3:0] exp);
        TMS   = t;
        RESET = r;
        exp_q.push_back(exp);
        ph_q.push_back(phase);
        if (!r) covered[{m_state, t}] = 1'b1;
        m_state = r ? 4'hF : ref_next(m_state, t);
        @(negedge TCK);
    endtask

    task automatic step_m(input logic t, input logic r);
        drive(t, r, r ? 4'hF : ref_next(m_state, t));
    endtask

    // Monitor: pops one expectation per TCK and compares all outputs
    initial begin
        logic [3:0]  e;
        int          p;
        logic [12:0] got, want;
        forever begin
            @(posedge TCK);
            #1;
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                p    = ph_q.pop_front();
                got  = {STATE, SELECT, ENABLE, TLR, CAPTURE_DR, SHIFT_DR,
                        UPDATE_DR, CAPTURE_IR, SHIFT_IR, UPDATE_IR};
                want = {e, ref_outs(e)};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL phase%0d outputs: got %h required %h", p, got, want);
                end
            end
            if (count_en) begin
                sel_cnt   += int'(SELECT);
                en_cnt    += int'(ENABLE);
                updir_cnt += int'(UPDATE_IR);
                shdr_cnt  += int'(SHIFT_DR);
            end
        end
    end

    task automatic check_cnt(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic start_count();
        sel_cnt = 0; en_cnt = 0; updir_cnt = 0; shdr_cnt = 0;
        count_en = 1'b1;
    endtask

    initial begin
        tgt[0]  = 4'hF; pbits[0]  = 8'b0;       plen[0]  = 0;
        tgt[1]  = 4'hC; pbits[1]  = 8'b0;       plen[1]  = 1;
        tgt[2]  = 4'h7; pbits[2]  = 8'b10;      plen[2]  = 2;
        tgt[3]  = 4'h6; pbits[3]  = 8'b010;     plen[3]  = 3;
        tgt[4]  = 4'h2; pbits[4]  = 8'b0010;    plen[4]  = 4;
        tgt[5]  = 4'h1; pbits[5]  = 8'b1010;    plen[5]  = 4;
        tgt[6]  = 4'h3; pbits[6]  = 8'b01010;   plen[6]  = 5;
        tgt[7]  = 4'h0; pbits[7]  = 8'b101010;  plen[7]  = 6;
        tgt[8]  = 4'h5; pbits[8]  = 8'b11010;   plen[8]  = 5;
        tgt[9]  = 4'h4; pbits[9]  = 8'b110;     plen[9]  = 3;
        tgt[10] = 4'hE; pbits[10] = 8'b0110;    plen[10] = 4;
        tgt[11] = 4'hA; pbits[11] = 8'b00110;   plen[11] = 5;
        tgt[12] = 4'h9; pbits[12] = 8'b10110;   plen[12] = 5;
        tgt[13] = 4'hB; pbits[13] = 8'b010110;  plen[13] = 6;
        tgt[14] = 4'h8; pbits[14] = 8'b1010110; plen[14] = 7;
        tgt[15] = 4'hD; pbits[15] = 8'b110110;  plen[15] = 6;

        // Reset and first step to RTI
        phase = 1;
        drive(1'b0, 1'b1, 4'hF);
        drive(1'b0, 1'b0, 4'hC);

        // IR scan: SelDR SelIR CapIR ShIR x3 Ex1IR UpdIR RTI
        phase = 2;
        start_count();
        drive(1'b1, 1'b0, 4'h7);
        drive(1'b1, 1'b0, 4'h4);
        drive(1'b0, 1'b0, 4'hE);
        drive(1'b0, 1'b0, 4'hA);
        drive(1'b0, 1'b0, 4'hA);
        drive(1'b0, 1'b0, 4'hA);
        drive(1'b1, 1'b0, 4'h9);
        drive(1'b1, 1'b0, 4'hD);
        drive(1'b0, 1'b0, 4'hC);
        count_en = 1'b0;
        check_cnt("ir_select_cycles", sel_cnt, 7);
        check_cnt("ir_enable_cycles", en_cnt, 3);
        check_cnt("ir_update_pulses", updir_cnt, 1);

        // DR scan with pause, then on to SelDR
        phase = 3;
        start_count();
        drive(1'b1, 1'b0, 4'h7);
        drive(1'b0, 1'b0, 4'h6);
        drive(1'b0, 1'b0, 4'h2);
        drive(1'b0, 1'b0, 4'h2);
        drive(1'b1, 1'b0, 4'h1);
        drive(1'b0, 1'b0, 4'h3);
        drive(1'b0, 1'b0, 4'h3);
        drive(1'b1, 1'b0, 4'h0);
        drive(1'b0, 1'b0, 4'h2);
        drive(1'b1, 1'b0, 4'h1);
        drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'h7);
        count_en = 1'b0;
        check_cnt("dr_select_cycles", sel_cnt, 0);
        check_cnt("dr_shift_cycles", shdr_cnt, 3);
        check_cnt("dr_enable_cycles", en_cnt, 3);

        // Reset in the middle of an IR shift
        phase = 4;
        drive(1'b1, 1'b0, 4'h4);
        drive(1'b1, 1'b0, 4'hF);
        drive(1'b0, 1'b0, 4'hC);
        start_count();
        drive(1'b1, 1'b0, 4'h7);
        drive(1'b1, 1'b0, 4'h4);
        drive(1'b0, 1'b0, 4'hE);
        drive(1'b0, 1'b0, 4'hA);
        drive(1'b1, 1'b1, 4'hF);
        drive(1'b0, 1'b0, 4'hC);
        count_en = 1'b0;
        check_cnt("abort_update_ir", updir_cnt, 0);

        // Five TMS=1 edges from every state reach TLR
        phase = 5;
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 1'b1, 4'hF);
            for (int j = 0; j < plen[k]; j++) begin
                if (j == plen[k] - 1) drive(pbits[k][j], 1'b0, tgt[k]);
                else                  step_m(pbits[k][j], 1'b0);
            end
            for (int j = 0; j < 4; j++) step_m(1'b1, 1'b0);
            drive(1'b1, 1'b0, 4'hF);
        end

        // Random TMS with occasional reset against the reference model
        phase = 6;
        for (int n = 0; n < 10000; n++) begin
            step_m(1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end

        RESET = 1'b0;
        TMS   = 1'b0;
        repeat (3) @(negedge TCK);
        check_cnt("scoreboard_drained", exp_q.size(), 0);
        checks++;
        if (covered !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL edge_coverage: got %h required ffffffff", covered);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
